conv3x3_mac: RTL

- Downstream consumer of the 3x3 window assembler. Takes one 72-bit window of nine 8-bit pixels per valid cycle.
- Computes the signed 3x3 convolution against a runtime-loadable kernel, normalises and saturates the result, and emits one 8-bit output pixel.
- Fully pipelined, 1 window/cycle throughput. Feeds the output pixel writer.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv3x3_mac_if.sv | 17 +
 rtl/conv_kernel_regs.sv | 53 +++++
 rtl/conv3x3_mac.sv | 75 +++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths, kernel types and window helpers for the 3x3 convolution MAC.
package conv_pkg;
  localparam int PIX_W      = 8;
  localparam int COEF_W     = 8;
  localparam int KERN_TAPS  = 9;
  localparam int KERN_ROWS  = 3;
  localparam int WIN_W      = KERN_TAPS * PIX_W;
  localparam int ACC_W      = 21;
  localparam int IDX_W      = 4;
  localparam int NORM_SHIFT = 4;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t [KERN_TAPS-1:0]    kernel_t;

  // Tap 0 (top-left) occupies the most significant byte of the window.
  function automatic logic [PIX_W-1:0] win_pix(input logic [WIN_W-1:0] win, input int i);
    return win[WIN_W-1-i*PIX_W -: PIX_W];
  endfunction

  function automatic kernel_t kern_identity(input int shift);
    kernel_t k;
    k    = '0;
    k[4] = coef_t'(1 << shift);
    return k;
  endfunction

  localparam kernel_t KERN_IDENTITY = kern_identity(NORM_SHIFT);
endpackage

// File: rtl/conv3x3_mac_if.sv
// Window input, coefficient load port and pixel output of the 3x3 convolution MAC.
interface conv3x3_mac_if;
  import conv_pkg::*;
  logic             win_valid;
  logic [WIN_W-1:0] win_data;
  logic             coef_we;
  logic [COEF_W-1:0] coef_data;
  logic             coef_restart;
  logic             coef_busy;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_out;

  modport master (output win_valid, win_data, coef_we, coef_data, coef_restart,
                  input  coef_busy, pix_valid, pix_out);
  modport slave  (input  win_valid, win_data, coef_we, coef_data, coef_restart,
                  output coef_busy, pix_valid, pix_out);
endinterface

// File: rtl/conv_kernel_regs.sv
// Shadow/active kernel registers: sequential k0..k8 load, atomic commit on the 9th write.
module conv_kernel_regs
  import conv_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    coef_we,
  input  coef_t   coef_data,
  input  logic    coef_restart,
  output logic    coef_busy,
  output kernel_t kern
);
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_LOADING = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  kernel_t          shadow;
  kernel_t          commit_set;

  // The last tap goes straight into the active set on the committing edge.
  always_comb begin
    commit_set                = shadow;
    commit_set[KERN_TAPS-1]   = coef_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      shadow <= '0;
      kern   <= kern_identity(SHIFT);
    end else if (coef_restart) begin
      state  <= ST_IDLE;
      idx    <= '0;
      shadow <= '0;
    end else if (coef_we) begin
      shadow[idx] <= coef_data;
      if (idx == IDX_W'(KERN_TAPS-1)) begin
        kern  <= commit_set;
        idx   <= '0;
        state <= ST_IDLE;
      end else begin
        idx   <= idx + 1'b1;
        state <= ST_LOADING;
      end
    end
  end

  assign coef_busy = (state == ST_LOADING);
endmodule

// File: rtl/conv3x3_mac.sv
// 3-stage signed 3x3 convolution: products, row sums, final sum/shift/clamp.
// Build option: CONV_ABS_EN takes |x| after the shift (edge-magnitude kernels).
module conv3x3_mac #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 4
) (
  input logic          clk,
  input logic          rst,
  conv3x3_mac_if.slave bus
);
  import conv_pkg::*;

  localparam int P_W    = PIX_W + 1 + COEF_W;
  localparam int STAGES = 3;
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  kernel_t                 kern;
  logic [STAGES-1:0]       vld_pipe;
  logic signed [P_W-1:0]   prod_q [KERN_TAPS];
  logic signed [ACC_W-1:0] row_q  [KERN_ROWS];
  logic signed [ACC_W-1:0] acc, shf, mag;
  logic [PIX_W-1:0]        sat, pix_q;

  conv_kernel_regs #(.SHIFT(SHIFT)) u_kregs (
    .clk         (clk),
    .rst         (rst),
    .coef_we     (bus.coef_we),
    .coef_data   (coef_t'(bus.coef_data)),
    .coef_restart(bus.coef_restart),
    .coef_busy   (bus.coef_busy),
    .kern        (kern)
  );

  // S1: pixels are unsigned, so zero-extend before the signed multiply.
  for (genvar i = 0; i < KERN_TAPS; i++) begin : g_tap
    always_ff @(posedge clk or posedge rst)
      if (rst) prod_q[i] <= '0;
      else     prod_q[i] <= P_W'($signed({1'b0, win_pix(bus.win_data, i)})) * P_W'(kern[i]);
  end

  // S2
  for (genvar r = 0; r < KERN_ROWS; r++) begin : g_row
    always_ff @(posedge clk or posedge rst)
      if (rst) row_q[r] <= '0;
      else     row_q[r] <= ACC_W'(prod_q[3*r]) + ACC_W'(prod_q[3*r+1]) + ACC_W'(prod_q[3*r+2]);
  end

  // S3
  always_comb begin
    acc = row_q[0] + row_q[1] + row_q[2];
    shf = acc >>> SHIFT;
`ifdef CONV_ABS_EN
    mag = shf[ACC_W-1] ? -shf : shf;
`else
    mag = shf;
`endif
    if (mag[ACC_W-1])      sat = '0;
    else if (mag > PIX_MAX) sat = '1;
    else                   sat = mag[PIX_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      pix_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], bus.win_valid};
      if (vld_pipe[STAGES-2]) pix_q <= sat;
    end
  end

  assign bus.pix_valid = vld_pipe[STAGES-1];
  assign bus.pix_out   = pix_q;
endmodule
